fifo_drain: RTL and testbench

Read-side controller for the synchronous 8-deep 32-bit FIFO. It issues FIFO read strobes, absorbs the FIFO's one-cycle registered read latency, and presents the words as a valid/ready stream to the downstream consumer. A 3-entry internal buffer sustains one word per cycle under continuous backpressure-free flow. Instantiated directly beside the FIFO; the FIFO's write side is untouched.

---
 rtl/fifo_drain.sv | 99 +++++++++
 tb/tb_fifo_drain.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - read-side drain controller for an 8-deep registered-read FIFO
//
// Issues FIFO read strobes, absorbs the FIFO's one-cycle read latency in a
// 3-entry ring buffer and presents the words as a valid/ready stream.
//
// Optional feature macro: FIFO_DRAIN_CNT_EN adds the word_cnt delivered-word counter.
//
// Ports:
//   clk         rising-edge clock, shared with the FIFO
//   rst_n       asynchronous active-low reset
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO registered read data, valid the cycle after fifo_ren
//   fifo_ren    FIFO read strobe
//   flush       synchronous discard of all buffered and in-flight words
//   out_valid   out_data holds a word
//   out_ready   consumer accepts the word
//   out_data    head-of-buffer word
//   word_cnt    delivered-word count (FIFO_DRAIN_CNT_EN only)

module fifo_drain #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_ren,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
`ifdef FIFO_DRAIN_CNT_EN
    ,
    output logic [15:0]   word_cnt
`endif
);

    logic [DW-1:0] buf_q [3];
    logic [1:0]    wr_idx;
    logic [1:0]    rd_idx;
    logic [1:0]    occ;
    logic          pending;
    logic [2:0]    fill;
    logic          pop;

    // Ring index advance: 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] idx_inc(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Words committed to the buffer plus the one in flight; reading only
    // while this is below 3 guarantees every returning word has a slot.
    assign fill      = {1'b0, occ} + {2'b00, pending};
    assign fifo_ren  = rst_n & ~fifo_empty & ~flush & (fill < 3'd3);
    assign out_valid = (occ != 2'd0);
    assign out_data  = buf_q[rd_idx];
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
            wr_idx  <= 2'd0;
            rd_idx  <= 2'd0;
            occ     <= 2'd0;
            pending <= 1'b0;
        end else if (flush) begin
            // A word returning from the FIFO this cycle is dropped too.
            wr_idx  <= 2'd0;
            rd_idx  <= 2'd0;
            occ     <= 2'd0;
            pending <= 1'b0;
        end else begin
            pending <= fifo_ren;
            if (pending) begin
                buf_q[wr_idx] <= fifo_data;
                wr_idx        <= idx_inc(wr_idx);
            end
            if (pop) begin
                rd_idx <= idx_inc(rd_idx);
            end
            occ <= occ + {1'b0, pending} - {1'b0, pop};
        end
    end

`ifdef FIFO_DRAIN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= 16'd0;
        end else if (flush) begin
            word_cnt <= 16'd0;
        end else if (pop) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// tb/tb_fifo_drain.sv - self-checking bench for fifo_drain with a behavioural FIFO and stream scoreboard

module tb_fifo_drain;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_ren;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
`ifdef FIFO_DRAIN_CNT_EN
    logic [15:0] word_cnt;
`endif

    always #5 clk = ~clk;

    fifo_drain #(.DW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_ren   (fifo_ren),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef FIFO_DRAIN_CNT_EN
        ,
        .word_cnt   (word_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural 8-deep FIFO with registered read data.
    logic        wr_en = 1'b0;
    logic [31:0] wr_word = '0;
    logic [31:0] fm [8];
    logic [2:0]  frd, fwr;
    int          fcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frd       <= '0;
            fwr       <= '0;
            fcnt      <= 0;
            fifo_data <= '0;
        end else begin
            if (wr_en) begin
                fm[fwr] <= wr_word;
                fwr     <= fwr + 3'd1;
            end
            if (fifo_ren) begin
                fifo_data <= fm[frd];
                frd       <= frd + 3'd1;
            end
            fcnt <= fcnt + int'(wr_en) - int'(fifo_ren);
        end
    end
    assign fifo_empty = (fcnt == 0);

    // Scoreboard: words taken from the FIFO but not yet delivered, tagged with
    // the cycle their read strobe was high. A word is deliverable two cycles later.
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] dlv[$];
    int          dlv_cyc[$];
    int          ren_log[$];
    int          cyc = 0;
    int          cnt_m = 0;
    logic        hold = 1'b0;
    logic [31:0] held = '0;

    always @(negedge clk) begin
        logic exp_valid;
        logic exp_ren;
        if (!rst_n) begin
            check("rst_fifo_ren", {31'd0, fifo_ren}, 32'd0);
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            sb.delete();
            cnt_m = 0;
            hold  = 1'b0;
        end else begin
            exp_valid = (sb.size() > 0) && (sb[0].cyc + 2 <= cyc);
            exp_ren   = !fifo_empty && !flush && (sb.size() < 3);
            check("fifo_ren", {31'd0, fifo_ren}, {31'd0, exp_ren});
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
            if (exp_valid && out_valid)
                check("out_data", out_data, sb[0].data);
            if (hold && out_valid)
                check("out_data_stable", out_data, held);
`ifdef FIFO_DRAIN_CNT_EN
            check("word_cnt", {16'd0, word_cnt}, cnt_m[31:0] & 32'hFFFF);
`endif
            if (fifo_ren) ren_log.push_back(cyc);
            if (flush) begin
                sb.delete();
                cnt_m = 0;
            end else begin
                if (exp_valid && out_ready) begin
                    dlv.push_back(out_data);
                    dlv_cyc.push_back(cyc);
                    void'(sb.pop_front());
                    cnt_m++;
                end
                if (exp_ren) sb.push_back('{fm[frd], cyc});
            end
            hold = out_valid && !out_ready && !flush;
            held = out_data;
        end
        cyc++;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_word = base + i;
            step(1);
        end
        wr_en = 1'b0;
    endtask

    initial begin
        int r0, d0;
        bit flushed;
        bit after_flush;

        // Reset state
        step(3);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_fifo_ren", {31'd0, fifo_ren}, 32'd0);
        check("reset_out_data", out_data, 32'd0);
`ifdef FIFO_DRAIN_CNT_EN
        check("reset_word_cnt", {16'd0, word_cnt}, 32'd0);
`endif
        rst_n = 1'b1;
        step(2);

        // 1: streaming with out_ready=1
        r0 = ren_log.size();
        d0 = dlv.size();
        out_ready = 1'b1;
        push_words(32'hA0, 8);
        step(12);
        check("t1_ren_count", ren_log.size() - r0, 32'd8);
        check("t1_dlv_count", dlv.size() - d0, 32'd8);
        if (dlv.size() - d0 == 8 && ren_log.size() - r0 == 8) begin
            for (int i = 0; i < 8; i++)
                check("t1_word", dlv[d0 + i], 32'hA0 + i);
            check("t1_latency", dlv_cyc[d0] - ren_log[r0], 32'd2);
            check("t1_no_gaps", dlv_cyc[d0 + 7] - dlv_cyc[d0], 32'd7);
        end
        check("t1_fifo_empty", {31'd0, fifo_empty}, 32'd1);
`ifdef FIFO_DRAIN_CNT_EN
        check("t1_word_cnt", {16'd0, word_cnt}, 32'd8);
`endif

        // 2: backpressure
        r0 = ren_log.size();
        d0 = dlv.size();
        out_ready = 1'b0;
        push_words(32'hB0, 8);
        step(10);
        check("t2_ren_pulses", ren_log.size() - r0, 32'd3);
        check("t2_head_valid", {31'd0, out_valid}, 32'd1);
        check("t2_head_data", out_data, 32'hB0);
        out_ready = 1'b1;
        step(20);
        check("t2_dlv_count", dlv.size() - d0, 32'd8);
        if (dlv.size() - d0 == 8) begin
            for (int i = 0; i < 8; i++)
                check("t2_word", dlv[d0 + i], 32'hB0 + i);
            check("t2_no_gaps", dlv_cyc[d0 + 7] - dlv_cyc[d0], 32'd7);
        end

        // 3: toggling out_ready
        r0 = ren_log.size();
        d0 = dlv.size();
        out_ready = 1'b0;
        push_words(32'hC0, 8);
        for (int i = 0; i < 40; i++) begin
            out_ready = ~out_ready;
            step(1);
        end
        out_ready = 1'b1;
        step(5);
        check("t3_ren_count", ren_log.size() - r0, 32'd8);
        check("t3_dlv_count", dlv.size() - d0, 32'd8);
        if (dlv.size() - d0 == 8)
            for (int i = 0; i < 8; i++)
                check("t3_word", dlv[d0 + i], 32'hC0 + i);

        // 4: flush while two words are buffered and one is in flight
        r0 = ren_log.size();
        d0 = dlv.size();
        out_ready   = 1'b0;
        flushed     = 1'b0;
        after_flush = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (after_flush) begin
                check("t4_valid_after_flush", {31'd0, out_valid}, 32'd0);
`ifdef FIFO_DRAIN_CNT_EN
                check("t4_word_cnt", {16'd0, word_cnt}, 32'd0);
`endif
                after_flush = 1'b0;
            end
            wr_en   = (i < 8);
            wr_word = 32'hD0 + i;
            if (!flushed && ren_log.size() - r0 == 3) begin
                flush       = 1'b1;
                flushed     = 1'b1;
                after_flush = 1'b1;
            end else begin
                flush = 1'b0;
            end
            step(1);
        end
        wr_en = 1'b0;
        flush = 1'b0;
        check("t4_flush_happened", {31'd0, flushed}, 32'd1);
        out_ready = 1'b1;
        step(20);
        check("t4_dlv_count", dlv.size() - d0, 32'd5);
        if (dlv.size() - d0 == 5)
            for (int i = 0; i < 5; i++)
                check("t4_word", dlv[d0 + i], 32'hD3 + i);

        // 5: asynchronous reset mid-stream
        out_ready = 1'b0;
        push_words(32'hE0, 4);
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_ren", {31'd0, fifo_ren}, 32'd0);
        check("t5_async_valid", {31'd0, out_valid}, 32'd0);
        check("t5_async_data", out_data, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);
        d0 = dlv.size();
        out_ready = 1'b1;
        push_words(32'h55, 1);
        step(8);
        check("t5_dlv_count", dlv.size() - d0, 32'd1);
        if (dlv.size() - d0 == 1)
            check("t5_first_word", dlv[d0], 32'h55);

        // 6: empty FIFO stays idle
        r0 = ren_log.size();
        d0 = dlv.size();
        for (int i = 0; i < 20; i++) begin
            check("t6_idle_ren", {31'd0, fifo_ren}, 32'd0);
            check("t6_idle_valid", {31'd0, out_valid}, 32'd0);
            step(1);
        end
        check("t6_ren_count", ren_log.size() - r0, 32'd0);
        check("t6_dlv_count", dlv.size() - d0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
